multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath (ifu, GPR, ALU, EXT, M1/M2/M3 muxes, dm_1k).
- Replaces the single-cycle decoder, so one datapath executes each instruction over 3-5+ states.
- Consumes the opcode/funct fields from the IR plus the ALU zero/overflow flags.
- Drives every datapath select and write-enable, and gates DM accesses with a ready handshake.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 47 ++++
 rtl/mc_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, instruction-class, ALU and select encodings for multicycle_ctrl
package mc_pkg;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXE    = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd15
  } state_t;
  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_SLT, C_ORI, C_LUI, C_ADDI,
    C_LW, C_LB, C_SW, C_SB, C_BEQ, C_J, C_JAL, C_JR
  } cls_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] GPR_RT  = 2'b00;
  localparam logic [1:0] GPR_RD  = 2'b01;
  localparam logic [1:0] GPR_OUT = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  function automatic logic is_load(cls_t c);
    return c == C_LW || c == C_LB;
  endfunction
  function automatic logic is_store(cls_t c);
    return c == C_SW || c == C_SB;
  endfunction
  function automatic logic is_imm(cls_t c);
    return c == C_ORI || c == C_LUI || c == C_ADDI;
  endfunction
  function automatic logic is_jump(cls_t c);
    return c == C_J || c == C_JAL || c == C_JR;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle (IR fields, ALU flags, DM ready in; selects/enables out)
// master = controller, slave = datapath. Optional trap line exists only with ILLEGAL_TRAP_EN.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       of;
  logic       mem_ready;
  logic       pc_wr;
  logic       ir_wr;
  logic       npc_sel;
  logic       jsome;
  logic       jr;
  logic       jal;
  logic [2:0] alu_op;
  logic       bsel;
  logic [1:0] extop;
  logic [1:0] gprsel;
  logic [1:0] wdsel;
  logic       gpr_wr;
  logic       dm_rd;
  logic       dm_wr;
  logic       sb;
  logic       lb;
  logic       instr_done;
  logic       mem_err;
  logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       trap;
`endif
  modport master (
    input  op, funct, zero, of, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    output trap,
`endif
    output pc_wr, ir_wr, npc_sel, jsome, jr, jal, alu_op, bsel, extop, gprsel,
           wdsel, gpr_wr, dm_rd, dm_wr, sb, lb, instr_done, mem_err, state
  );
  modport slave (
    output op, funct, zero, of, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    input  trap,
`endif
    input  pc_wr, ir_wr, npc_sel, jsome, jr, jal, alu_op, bsel, extop, gprsel,
           wdsel, gpr_wr, dm_rd, dm_wr, sb, lb, instr_done, mem_err, state
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational IR op/funct -> instruction class
// Ports: i_op (IR[31:26]), i_funct (IR[5:0]), o_cls (class, C_ILL for undefined encodings).
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls
);
  always_comb begin
    o_cls = C_ILL;
    case (i_op)
      OP_R: case (i_funct)
        FN_ADDU: o_cls = C_ADDU;
        FN_SUBU: o_cls = C_SUBU;
        FN_SLT:  o_cls = C_SLT;
        FN_JR:   o_cls = C_JR;
        default: o_cls = C_ILL;
      endcase
      OP_ORI:  o_cls = C_ORI;
      OP_LUI:  o_cls = C_LUI;
      OP_ADDI: o_cls = C_ADDI;
      OP_LW:   o_cls = C_LW;
      OP_LB:   o_cls = C_LB;
      OP_SW:   o_cls = C_SW;
      OP_SB:   o_cls = C_SB;
      OP_BEQ:  o_cls = C_BEQ;
      OP_J:    o_cls = C_J;
      OP_JAL:  o_cls = C_JAL;
      default: o_cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS sequencer driving datapath selects/enables with a DM ready handshake
// Ports: clk, rst (async active-low), bus (multicycle_ctrl_if.master: op/funct/zero/of/mem_ready in,
// all datapath controls, instr_done, mem_err, state out). Macro ILLEGAL_TRAP_EN enables the TRAP state.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 8,
  parameter int WAIT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  multicycle_ctrl_if.master bus
);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  state_t              r_state, w_next;
  cls_t                r_cls, w_cls;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mem_err;
  logic                w_wait_cyc, w_timeout;
  mc_decode u_decode (.i_op(bus.op), .i_funct(bus.funct), .o_cls(w_cls));
  assign w_wait_cyc = r_state == S_MEMRD || r_state == S_MEMWR;
  // Timeout fires on the MEM_WAIT_MAX-th unanswered cycle so that cycle is the last one with a request.
  assign w_timeout  = w_wait_cyc && !bus.mem_ready && r_wait == WAIT_W'(MEM_WAIT_MAX - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cls     <= C_ILL;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
      r_wait <= (w_wait_cyc && !bus.mem_ready) ? r_wait + 1'b1 : '0;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end
  always_comb begin
    w_next         = r_state;
    bus.pc_wr      = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.npc_sel    = 1'b0;
    bus.jsome      = 1'b0;
    bus.jr         = 1'b0;
    bus.jal        = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.bsel       = 1'b0;
    bus.extop      = EXT_ZERO;
    bus.gprsel     = GPR_RT;
    bus.wdsel      = WD_ALU;
    bus.gpr_wr     = 1'b0;
    bus.dm_rd      = 1'b0;
    bus.dm_wr      = 1'b0;
    bus.sb         = 1'b0;
    bus.lb         = 1'b0;
    bus.instr_done = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.ir_wr = 1'b1;
        bus.pc_wr = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: w_next = w_cls == C_ILL ? ILL_NEXT :
                         (is_load(w_cls) || is_store(w_cls)) ? S_MEMADR :
                         w_cls == C_BEQ ? S_BRANCH :
                         is_jump(w_cls) ? S_JUMP : S_EXE;
      S_EXE: begin
        bus.alu_op = r_cls == C_SUBU ? ALU_SUB : r_cls == C_SLT ? ALU_SLT :
                     r_cls == C_ORI ? ALU_OR : r_cls == C_LUI ? ALU_LUI : ALU_ADD;
        bus.bsel   = is_imm(r_cls);
        bus.extop  = r_cls == C_LUI ? EXT_LUI : r_cls == C_ADDI ? EXT_SIGN : EXT_ZERO;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.gpr_wr     = 1'b1;
        // addi overflow redirects the write to the $30 record register
        bus.gprsel     = !is_imm(r_cls) ? GPR_RD : (r_cls == C_ADDI && bus.of) ? GPR_OUT : GPR_RT;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEMADR: begin
        bus.bsel  = 1'b1;
        bus.extop = EXT_SIGN;
        w_next    = is_load(r_cls) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.dm_rd      = 1'b1;
        bus.lb         = r_cls == C_LB;
        bus.instr_done = w_timeout;
        w_next         = bus.mem_ready ? S_MEMWB : w_timeout ? S_FETCH : S_MEMRD;
      end
      S_MEMWB: begin
        bus.gpr_wr     = 1'b1;
        bus.wdsel      = WD_DM;
        bus.lb         = r_cls == C_LB;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEMWR: begin
        bus.dm_wr      = 1'b1;
        bus.sb         = r_cls == C_SB;
        bus.instr_done = bus.mem_ready || w_timeout;
        w_next         = (bus.mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
      end
      S_BRANCH: begin
        bus.alu_op     = ALU_SUB;
        bus.npc_sel    = 1'b1;
        bus.pc_wr      = bus.zero;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_wr      = 1'b1;
        bus.jsome      = r_cls == C_J || r_cls == C_JAL;
        bus.jal        = r_cls == C_JAL;
        bus.gpr_wr     = r_cls == C_JAL;
        bus.wdsel      = r_cls == C_JAL ? WD_PC4 : WD_ALU;
        bus.gprsel     = r_cls == C_JAL ? GPR_OUT : GPR_RT;
        bus.jr         = r_cls == C_JR;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end
  assign bus.state   = r_state;
  assign bus.mem_err = r_mem_err;
`ifdef ILLEGAL_TRAP_EN
  assign bus.trap    = r_state == S_TRAP;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream vs a per-instruction cycle-schedule model
module tb_multicycle_ctrl;
  localparam int MAXW = 8;
  typedef struct packed {
    logic pc_wr, ir_wr, npc_sel, jsome, jr, jal;
    logic [2:0] alu_op;
    logic bsel;
    logic [1:0] extop, gprsel, wdsel;
    logic gpr_wr, dm_rd, dm_wr, sb, lb, instr_done, mem_err;
    logic [3:0] state;
  } out_t;
  typedef struct packed {
    logic [5:0] op, funct;
    logic zero, of, rdy;
  } in_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .WAIT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  out_t got, cur;
  in_t  cur_in;
  in_t  in_q[$];
  out_t exp_q[$];
  logic valid = 1'b0;
  logic err = 1'b0;
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  logic [11:0] tbl [16];
  assign got = {bus.pc_wr, bus.ir_wr, bus.npc_sel, bus.jsome, bus.jr, bus.jal, bus.alu_op,
                bus.bsel, bus.extop, bus.gprsel, bus.wdsel, bus.gpr_wr, bus.dm_rd, bus.dm_wr,
                bus.sb, bus.lb, bus.instr_done, bus.mem_err, bus.state};
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      n_cmp++;
      if (got !== cur) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got %h want %h (state got %0d want %0d)", cyc, got, cur, got.state, cur.state);
      end
    end
  end
  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, g, e);
    end
  endtask
  function automatic in_t rnd_in();
    in_t r;
    r.op = 6'($urandom);
    r.funct = 6'($urandom);
    r.zero = 1'($urandom);
    r.of = 1'($urandom);
    r.rdy = 1'($urandom);
    return r;
  endfunction
  task automatic push(input in_t i, input out_t o);
    o.mem_err = err;
    in_q.push_back(i);
    exp_q.push_back(o);
  endtask
  // expected cycle-by-cycle schedule of one instruction, starting at its FETCH
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int waits, input logic zv, input logic ofv);
    in_t i;
    out_t o;
    logic r, addu, subu, slt, jr, ori, lui, addi, lw, lb, sw, sb, beq, j, jal, rt, imm, ld, st, to;
    int n;
    r = op == 6'h00;
    addu = r && fn == 6'h21; subu = r && fn == 6'h23; slt = r && fn == 6'h2a; jr = r && fn == 6'h08;
    ori = op == 6'h0d; lui = op == 6'h0f; addi = op == 6'h08;
    lw = op == 6'h23; lb = op == 6'h20; sw = op == 6'h2b; sb = op == 6'h28;
    beq = op == 6'h04; j = op == 6'h02; jal = op == 6'h03;
    rt = addu || subu || slt; imm = ori || lui || addi; ld = lw || lb; st = sw || sb;
    i = rnd_in(); o = '0; o.state = 4'd1; o.ir_wr = 1'b1; o.pc_wr = 1'b1; push(i, o);
    i = rnd_in(); i.op = op; i.funct = fn; o = '0; o.state = 4'd2; push(i, o);
    if (rt || imm) begin
      i = rnd_in(); o = '0; o.state = 4'd3; o.bsel = imm;
      o.alu_op = subu ? 3'd1 : slt ? 3'd3 : ori ? 3'd2 : lui ? 3'd4 : 3'd0;
      o.extop = lui ? 2'd2 : addi ? 2'd1 : 2'd0;
      push(i, o);
      i = rnd_in(); i.of = ofv; o = '0; o.state = 4'd4; o.gpr_wr = 1'b1; o.instr_done = 1'b1;
      o.gprsel = rt ? 2'd1 : (addi && ofv) ? 2'd2 : 2'd0;
      push(i, o);
    end else if (ld || st) begin
      i = rnd_in(); o = '0; o.state = 4'd5; o.bsel = 1'b1; o.extop = 2'd1; push(i, o);
      to = waits >= MAXW;
      n = to ? MAXW : waits + 1;
      for (int k = 0; k < n; k++) begin
        i = rnd_in(); i.rdy = !to && k == n - 1;
        o = '0; o.state = ld ? 4'd6 : 4'd8; o.dm_rd = ld; o.dm_wr = st; o.lb = lb; o.sb = sb;
        o.instr_done = (k == n - 1) && (to || st);
        push(i, o);
      end
      if (to) err = 1'b1;
      if (ld && !to) begin
        i = rnd_in(); o = '0; o.state = 4'd7; o.gpr_wr = 1'b1; o.wdsel = 2'd1; o.lb = lb; o.instr_done = 1'b1;
        push(i, o);
      end
    end else if (beq) begin
      i = rnd_in(); i.zero = zv; o = '0; o.state = 4'd9; o.alu_op = 3'd1; o.npc_sel = 1'b1;
      o.pc_wr = zv; o.instr_done = 1'b1;
      push(i, o);
    end else if (j || jal || jr) begin
      i = rnd_in(); o = '0; o.state = 4'd10; o.pc_wr = 1'b1; o.jsome = j || jal; o.jal = jal;
      o.gpr_wr = jal; o.wdsel = jal ? 2'd2 : 2'd0; o.gprsel = jal ? 2'd2 : 2'd0; o.jr = jr; o.instr_done = 1'b1;
      push(i, o);
    end
  endtask
  task automatic drive(input in_t i);
    bus.op = i.op; bus.funct = i.funct; bus.zero = i.zero; bus.of = i.of; bus.mem_ready = i.rdy;
  endtask
  task automatic run_q();
    while (in_q.size() > 0) begin
      @(posedge clk);
      #1;
      cur_in = in_q.pop_front();
      cur = exp_q.pop_front();
      drive(cur_in);
      valid = 1'b1;
    end
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b1;
    err = 1'b0;
    cur = '0;
    drive(rnd_in());
    valid = 1'b1;
  endtask
  initial begin
    int dmrd;
    logic [11:0] e;
    tbl = '{12'h021, 12'h023, 12'h02a, 12'h008, {6'h0d, 6'h00}, {6'h0f, 6'h00}, {6'h08, 6'h00},
            {6'h23, 6'h00}, {6'h20, 6'h00}, {6'h2b, 6'h00}, {6'h28, 6'h00}, {6'h04, 6'h00},
            {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00}, {6'h00, 6'h3f}};
    drive(rnd_in());
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(got), 32'd0);
    release_rst();
    build(6'h00, 6'h21, 0, 1'b0, 1'b1);
    build(6'h23, 6'h00, 2, 1'b0, 1'b0);
    build(6'h2b, 6'h00, 100, 1'b0, 1'b0);
    build(6'h04, 6'h00, 0, 1'b1, 1'b0);
    build(6'h04, 6'h00, 0, 1'b0, 1'b0);
    build(6'h03, 6'h00, 0, 1'b0, 1'b0);
    build(6'h00, 6'h08, 0, 1'b0, 1'b0);
    check("addu_done_c5", {exp_q[3].instr_done, exp_q[3].gpr_wr, exp_q[3].gprsel, exp_q[3].state}, {1'b1, 1'b1, 2'b01, 4'd4});
    check("addu_exe_nowr", {exp_q[2].gpr_wr, exp_q[2].state}, {1'b0, 4'd3});
    dmrd = 0;
    for (int k = 4; k <= 10; k++) dmrd += int'(exp_q[k].dm_rd);
    check("lw_dm_rd_cycles", dmrd, 3);
    check("lw_memwb", {exp_q[10].wdsel, exp_q[10].gpr_wr, exp_q[10].state}, {2'b01, 1'b1, 4'd7});
    check("sw_to_last", {exp_q[21].dm_wr, exp_q[21].instr_done, exp_q[21].mem_err}, 3'b110);
    check("sw_to_after", {exp_q[22].dm_wr, exp_q[22].mem_err, exp_q[22].state}, {1'b0, 1'b1, 4'd1});
    check("beq_z1", {exp_q[24].pc_wr, exp_q[24].npc_sel}, 2'b11);
    check("beq_z0", {exp_q[27].pc_wr, exp_q[27].npc_sel}, 2'b01);
    check("jal", {exp_q[30].pc_wr, exp_q[30].jsome, exp_q[30].jal, exp_q[30].gpr_wr, exp_q[30].wdsel, exp_q[30].gprsel}, {4'b1111, 2'b10, 2'b10});
    check("jr", {exp_q[33].jr, exp_q[33].gpr_wr, exp_q[33].pc_wr}, 3'b101);
    run_q();
    for (int t = 0; t < 150; t++) begin
      e = tbl[$urandom_range(15)];
      build(e[11:6], e[11:6] == 6'h00 ? e[5:0] : 6'($urandom), $urandom_range(9), 1'($urandom), 1'($urandom));
      run_q();
    end
    build(6'h2b, 6'h00, 100, 1'b0, 1'b0);
    while (in_q.size() > 6) begin
      void'(in_q.pop_back());
      void'(exp_q.pop_back());
    end
    run_q();
    @(negedge clk);
    #1;
    valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_memwr", {bus.dm_wr, bus.gpr_wr, bus.mem_err, bus.state}, 7'd0);
    release_rst();
    build(6'h3f, 6'h00, 0, 1'b0, 1'b0);
    build(6'h00, 6'h23, 0, 1'b0, 1'b0);
    build(6'h08, 6'h00, 0, 1'b0, 1'b1);
    run_q();
    @(negedge clk);
    #1;
    valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
